// File: rtl/jtframe_upi_dbb.sv
// jtframe_upi_dbb: host-side Data Bus Buffer of a UPI-41/42 MCU.
// Holds DBBIN, DBBOUT and STATUS (OBF, IBF, F0, F1, user bits [7:4]) and
// produces the MCU-side IBF event for each accepted host write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   host_cs_i/a0_i/wr_i/rd_i host bus control (strobes are levels)
//   host_din_i / host_dout_o host write data / combinational read data
//   host_irq_o               OBF interrupt to host
//   mcu_dbbin_o              DBBIN contents to the MCU core
//   mcu_in_i / mcu_out_i     IN A,DBB / OUT DBB,A pulses
//   mcu_dout_i               data for OUT DBB,A and MOV STS,A
//   mcu_sts_wr_i             MOV STS,A pulse (bits 7:4)
//   mcu_f0_op_i/mcu_f1_op_i  00 none, 01 clear, 10 complement, 11 no-op
//   ibf_o, obf_o, f0_o, f1_o status flags
//   ibf_evt_o                one-cycle pulse per accepted host write
//   ovr_o                    one-cycle pulse when a write overwrote unread data
module jtframe_upi_dbb #(
    parameter bit STS_EN  = 1'b1,
    parameter bit OBF_IRQ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_cs_i,
    input  logic       host_a0_i,
    input  logic       host_wr_i,
    input  logic       host_rd_i,
    input  logic [7:0] host_din_i,
    output logic [7:0] host_dout_o,
    output logic       host_irq_o,
    output logic [7:0] mcu_dbbin_o,
    input  logic       mcu_in_i,
    input  logic       mcu_out_i,
    input  logic [7:0] mcu_dout_i,
    input  logic       mcu_sts_wr_i,
    input  logic [1:0] mcu_f0_op_i,
    input  logic [1:0] mcu_f1_op_i,
    output logic       ibf_o,
    output logic       obf_o,
    output logic       f0_o,
    output logic       f1_o,
    output logic       ibf_evt_o,
    output logic       ovr_o
);

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;

    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_CPL = 2'b10;

    logic [DW-1:0] dbbin_q,  dbbin_d;
    logic [DW-1:0] dbbout_q, dbbout_d;
    logic [SW-1:0] sts_hi_q, sts_hi_d;
    logic          ibf_q,    ibf_d;
    logic          obf_q,    obf_d;
    logic          f0_q,     f0_d;
    logic          f1_q,     f1_d;
    logic          evt_q,    evt_d;
    logic          ovr_q,    ovr_d;
    logic          irq_q,    irq_d;
    // Edge-detect history plus an arm flag that suppresses detection in the
    // first cycle after reset, so a strobe held through reset is ignored.
    logic          wr_q,     wr_d;
    logic          rd_q,     rd_d;
    logic          rd_a0_q,  rd_a0_d;
    logic          arm_q,    arm_d;

    logic          wr_s, rd_s;
    logic          wr_evt, rd_rise, rd_end;
    logic [DW-1:0] status;

    assign wr_s    = host_cs_i & host_wr_i;
    assign rd_s    = host_cs_i & host_rd_i;
    assign wr_evt  = arm_q & wr_s & ~wr_q;
    assign rd_rise = rd_s & ~rd_q;
    // Only data reads (a0 latched low at strobe rise) consume DBBOUT.
    assign rd_end  = arm_q & ~rd_s & rd_q & ~rd_a0_q;

    assign status  = {(STS_EN ? sts_hi_q : SW'(0)), f1_q, f0_q, ibf_q, obf_q};

    // Host read mux, combinational so data is valid while the strobe is high
    always_comb begin
        host_dout_o = '0;
        if (rd_s) begin
            host_dout_o = host_a0_i ? status : dbbout_q;
        end
    end

    // Next-state logic with set-wins priority for IBF/OBF and host-wins for F1
    always_comb begin
        dbbin_d  = dbbin_q;
        dbbout_d = dbbout_q;
        sts_hi_d = sts_hi_q;
        ibf_d    = ibf_q;
        obf_d    = obf_q;
        f0_d     = f0_q;
        f1_d     = f1_q;
        evt_d    = wr_evt;
        ovr_d    = wr_evt & ibf_q & ~mcu_in_i;
        wr_d     = wr_s;
        rd_d     = rd_s;
        rd_a0_d  = rd_a0_q;
        arm_d    = 1'b1;

        // A read already in progress when detection arms is treated as a status read
        if (rd_rise) begin
            rd_a0_d = arm_q ? host_a0_i : 1'b1;
        end

        if (mcu_in_i) begin
            ibf_d = 1'b0;
        end
        if (wr_evt) begin
            ibf_d   = 1'b1;
            dbbin_d = host_din_i;
        end

        if (rd_end) begin
            obf_d = 1'b0;
        end
        if (mcu_out_i) begin
            obf_d    = 1'b1;
            dbbout_d = mcu_dout_i;
        end

        if (mcu_sts_wr_i && STS_EN) begin
            sts_hi_d = mcu_dout_i[7:4];
        end

        case (mcu_f0_op_i)
            OP_CLR:  f0_d = 1'b0;
            OP_CPL:  f0_d = ~f0_q;
            default: f0_d = f0_q;
        endcase

        case (mcu_f1_op_i)
            OP_CLR:  f1_d = 1'b0;
            OP_CPL:  f1_d = ~f1_q;
            default: f1_d = f1_q;
        endcase
        if (wr_evt) begin
            f1_d = host_a0_i;
        end

        irq_d = OBF_IRQ ? obf_d : 1'b0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dbbin_q  <= '0;
            dbbout_q <= '0;
            sts_hi_q <= '0;
            ibf_q    <= 1'b0;
            obf_q    <= 1'b0;
            f0_q     <= 1'b0;
            f1_q     <= 1'b0;
            evt_q    <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            rd_a0_q  <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            dbbin_q  <= dbbin_d;
            dbbout_q <= dbbout_d;
            sts_hi_q <= sts_hi_d;
            ibf_q    <= ibf_d;
            obf_q    <= obf_d;
            f0_q     <= f0_d;
            f1_q     <= f1_d;
            evt_q    <= evt_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rd_a0_q  <= rd_a0_d;
            arm_q    <= arm_d;
        end
    end

    assign mcu_dbbin_o = dbbin_q;
    assign host_irq_o  = irq_q;
    assign ibf_o       = ibf_q;
    assign obf_o       = obf_q;
    assign f0_o        = f0_q;
    assign f1_o        = f1_q;
    assign ibf_evt_o   = evt_q;
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_jtframe_upi_dbb.sv
// tb_jtframe_upi_dbb: directed bench for jtframe_upi_dbb. A second instance
// with STS_EN=0 / OBF_IRQ=0 shares all inputs to cover the parameter variants.
module tb_jtframe_upi_dbb;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_cs, host_a0, host_wr, host_rd;
    logic [7:0] host_din;
    logic       mcu_in, mcu_out, mcu_sts_wr;
    logic [7:0] mcu_dout;
    logic [1:0] mcu_f0_op, mcu_f1_op;

    logic [7:0] host_dout, mcu_dbbin;
    logic       host_irq, ibf, obf, f0, f1, ibf_evt, ovr;
    logic [7:0] host_dout2, mcu_dbbin2;
    logic       host_irq2, ibf2, obf2, f02, f12, ibf_evt2, ovr2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtframe_upi_dbb #(.STS_EN(1'b1), .OBF_IRQ(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .host_cs_i(host_cs), .host_a0_i(host_a0), .host_wr_i(host_wr), .host_rd_i(host_rd),
        .host_din_i(host_din), .host_dout_o(host_dout), .host_irq_o(host_irq),
        .mcu_dbbin_o(mcu_dbbin), .mcu_in_i(mcu_in), .mcu_out_i(mcu_out),
        .mcu_dout_i(mcu_dout), .mcu_sts_wr_i(mcu_sts_wr),
        .mcu_f0_op_i(mcu_f0_op), .mcu_f1_op_i(mcu_f1_op),
        .ibf_o(ibf), .obf_o(obf), .f0_o(f0), .f1_o(f1), .ibf_evt_o(ibf_evt), .ovr_o(ovr)
    );

    jtframe_upi_dbb #(.STS_EN(1'b0), .OBF_IRQ(1'b0)) u_dut2 (
        .clk(clk), .rst(rst),
        .host_cs_i(host_cs), .host_a0_i(host_a0), .host_wr_i(host_wr), .host_rd_i(host_rd),
        .host_din_i(host_din), .host_dout_o(host_dout2), .host_irq_o(host_irq2),
        .mcu_dbbin_o(mcu_dbbin2), .mcu_in_i(mcu_in), .mcu_out_i(mcu_out),
        .mcu_dout_i(mcu_dout), .mcu_sts_wr_i(mcu_sts_wr),
        .mcu_f0_op_i(mcu_f0_op), .mcu_f1_op_i(mcu_f1_op),
        .ibf_o(ibf2), .obf_o(obf2), .f0_o(f02), .f1_o(f12), .ibf_evt_o(ibf_evt2), .ovr_o(ovr2)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        host_cs = 1'b0; host_a0 = 1'b0; host_wr = 1'b0; host_rd = 1'b0; host_din = '0;
        mcu_in = 1'b0; mcu_out = 1'b0; mcu_sts_wr = 1'b0; mcu_dout = '0;
        mcu_f0_op = 2'b00; mcu_f1_op = 2'b00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_flags", {ibf_evt, ovr, host_irq, f1, f0, ibf, obf}, 8'h00);
        check("rst_dbbin", mcu_dbbin, 8'h00);
        host_cs = 1'b1; host_rd = 1'b1; host_a0 = 1'b1; #1;
        check("rst_status", host_dout, 8'h00);
        host_rd = 1'b0; #1;
        check("idle_dout", host_dout, 8'h00);

        // 1: data write, single ibf_evt pulse, mcu_in clears ibf
        host_a0 = 1'b0; host_din = 8'h5A; host_wr = 1'b1;
        tick();
        check("t1_ibf_f1_evt", {ibf, f1, ibf_evt, ovr}, 4'b1010);
        check("t1_dbbin", mcu_dbbin, 8'h5A);
        tick();
        check("t1_evt_once", {ibf, ibf_evt}, 2'b10);
        host_wr = 1'b0;
        tick();
        mcu_in = 1'b1;
        tick();
        mcu_in = 1'b0;
        check("t1_mcu_in", ibf, 1'b0);

        // 2: command write sets f1; status read has no side effect
        host_a0 = 1'b1; host_din = 8'hC3; host_wr = 1'b1;
        tick();
        check("t2_f1_ibf", {f1, ibf}, 2'b11);
        host_wr = 1'b0;
        tick();
        host_rd = 1'b1; #1;
        check("t2_status", host_dout, 8'h0A);
        tick();
        host_rd = 1'b0;
        tick();
        check("t2_no_change", {f1, f0, ibf, obf}, 4'b1010);
        mcu_in = 1'b1;
        tick();
        mcu_in = 1'b0;

        // 3: mcu_out -> obf/irq; data read clears obf at strobe fall
        mcu_out = 1'b1; mcu_dout = 8'hA7;
        tick();
        mcu_out = 1'b0;
        check("t3_obf_irq", {obf, host_irq, host_irq2}, 3'b110);
        host_a0 = 1'b0; host_rd = 1'b1; #1;
        check("t3_data", host_dout, 8'hA7);
        tick();
        check("t3_obf_held", obf, 1'b1);
        host_rd = 1'b0;
        tick();
        check("t3_obf_clr", {obf, host_irq}, 2'b00);

        // 4: overrun on second write without mcu_in
        host_din = 8'h11; host_wr = 1'b1;
        tick();
        check("t4_first_ovr", ovr, 1'b0);
        host_wr = 1'b0;
        tick();
        host_din = 8'h22; host_wr = 1'b1;
        tick();
        check("t4_ovr", {ovr, ibf_evt, ibf}, 3'b111);
        check("t4_dbbin", mcu_dbbin, 8'h22);
        host_wr = 1'b0;
        tick();
        check("t4_ovr_pulse", ovr, 1'b0);

        // 5: simultaneous write+mcu_in, read-end+mcu_out
        host_din = 8'h33; host_wr = 1'b1; mcu_in = 1'b1;
        tick();
        mcu_in = 1'b0; host_wr = 1'b0;
        check("t5_wr_vs_in", {ibf, ovr, ibf_evt}, 3'b101);
        check("t5_dbbin", mcu_dbbin, 8'h33);
        mcu_out = 1'b1; mcu_dout = 8'h55;
        tick();
        mcu_out = 1'b0;
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0; mcu_out = 1'b1; mcu_dout = 8'h66;
        tick();
        mcu_out = 1'b0;
        check("t5_rd_vs_out", obf, 1'b1);
        host_rd = 1'b1; #1;
        check("t5_new_data", host_dout, 8'h66);
        tick();
        host_rd = 1'b0;
        tick();
        check("t5_obf_clr", obf, 1'b0);
        mcu_in = 1'b1;
        tick();
        mcu_in = 1'b0;

        // 6: user status bits and F0/F1 ops
        mcu_sts_wr = 1'b1; mcu_dout = 8'hF0; mcu_f0_op = 2'b10;
        tick();
        mcu_sts_wr = 1'b0; mcu_f0_op = 2'b00;
        host_a0 = 1'b1; host_rd = 1'b1; #1;
        check("t6_status_en", host_dout, 8'hF4);
        check("t6_status_dis", host_dout2, 8'h04);
        host_rd = 1'b0;
        mcu_f1_op = 2'b10;
        tick();
        check("t6_f1_cpl", f1, 1'b1);
        host_a0 = 1'b0; host_wr = 1'b1;
        tick();
        mcu_f1_op = 2'b00; host_wr = 1'b0;
        check("t6_f1_host_wins", {f1, f0}, 2'b01);
        mcu_f0_op = 2'b01;
        tick();
        mcu_f0_op = 2'b00;
        check("t6_f0_clr", f0, 1'b0);

        // Reset in the middle of a held write strobe
        host_a0 = 1'b1; host_din = 8'h99; host_wr = 1'b1;
        tick();
        check("rs_event", {ibf, f1}, 2'b11);
        rst = 1'b1;
        tick();
        check("rs_cleared", {ibf_evt, ovr, host_irq, f1, f0, ibf, obf}, 8'h00);
        check("rs_dbbin", mcu_dbbin, 8'h00);
        rst = 1'b0;
        tick();
        tick();
        check("rs_no_event", {ibf_evt, ibf, f1}, 3'b000);
        host_rd = 1'b1; #1;
        check("rs_status", host_dout, 8'h00);
        tick();
        check("rs_still_quiet", {ibf_evt, ibf, mcu_dbbin}, 10'h000);
        host_wr = 1'b0; host_rd = 1'b0; host_cs = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
